// File: rtl/fp_sum_normalizer_if.sv
// Handshake and data bundle for the post-adder normalizer: the upstream sum
// request, the packed result, and a debug view of the FSM state.
interface fp_sum_normalizer_if #(
  parameter int MW = 24,
  parameter int EW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [MW:0]   z_in;
  logic          eff_sub;
  logic          sign_in;
  logic [EW-1:0] exp_in;
  logic          out_valid;
  logic          out_ready;
  logic          sign_out;
  logic [EW-1:0] exp_out;
  logic [MW-2:0] mant_out;
  logic          zero_out;
  logic          ovf_out;
  logic          unf_out;
  logic [1:0]    dbg_state;

  // Both sides use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid and its data stay put until then.
  modport master (
    output in_valid, z_in, eff_sub, sign_in, exp_in, out_ready,
    input  in_ready, out_valid, sign_out, exp_out, mant_out,
           zero_out, ovf_out, unf_out, dbg_state
  );
  modport slave (
    input  in_valid, z_in, eff_sub, sign_in, exp_in, out_ready,
    output in_ready, out_valid, sign_out, exp_out, mant_out,
           zero_out, ovf_out, unf_out, dbg_state
  );
endinterface

// File: rtl/fp_sum_normalizer.sv
// Post-adder stage: recovers sign/magnitude of the raw mantissa sum, then
// normalizes it one left shift per cycle and presents the packed result.
module fp_sum_normalizer #(
  parameter int MW = 24,
  parameter int EW = 8
) (
  input  logic               clk,
  input  logic               rst,
  fp_sum_normalizer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RECOVER, S_NORM, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [MW:0]   r_z, w_z_nxt;
  logic          r_eff_sub, w_eff_sub_nxt;
  logic          r_sign_in, w_sign_in_nxt;
  logic [EW-1:0] r_exp_in, w_exp_in_nxt;
  logic [MW:0]   r_mag, w_mag_nxt;
  logic [EW:0]   r_exp, w_exp_nxt;
  logic          r_sign, w_sign_nxt;
  logic          r_sign_out, w_sign_out_nxt;
  logic [EW-1:0] r_exp_out, w_exp_out_nxt;
  logic [MW-2:0] r_mant_out, w_mant_out_nxt;
  logic          r_zero, w_zero_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic          r_unf, w_unf_nxt;

  logic          w_in_ready;
  logic          w_neg;
  logic          w_carry;
  logic [MW:0]   w_abs;
  logic [EW:0]   w_exp_inc;

  // Ready is gated by rst so nothing is accepted during a reset cycle.
  assign w_in_ready = (r_state == S_IDLE) && !rst;
  assign w_neg      = r_eff_sub && r_z[MW];
  assign w_carry    = !r_eff_sub && r_z[MW];
  assign w_abs      = w_neg ? ((~r_z) + {{MW{1'b0}}, 1'b1}) : r_z;
  assign w_exp_inc  = {1'b0, r_exp_in} + {{EW{1'b0}}, 1'b1};

  always_comb begin
    w_state_nxt    = r_state;
    w_z_nxt        = r_z;
    w_eff_sub_nxt  = r_eff_sub;
    w_sign_in_nxt  = r_sign_in;
    w_exp_in_nxt   = r_exp_in;
    w_mag_nxt      = r_mag;
    w_exp_nxt      = r_exp;
    w_sign_nxt     = r_sign;
    w_sign_out_nxt = r_sign_out;
    w_exp_out_nxt  = r_exp_out;
    w_mant_out_nxt = r_mant_out;
    w_zero_nxt     = r_zero;
    w_ovf_nxt      = r_ovf;
    w_unf_nxt      = r_unf;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && w_in_ready) begin
          w_z_nxt       = bus.z_in;
          w_eff_sub_nxt = bus.eff_sub;
          w_sign_in_nxt = bus.sign_in;
          w_exp_in_nxt  = bus.exp_in;
          w_state_nxt   = S_RECOVER;
        end
      end
      S_RECOVER: begin
        w_zero_nxt = 1'b0;
        w_ovf_nxt  = 1'b0;
        w_unf_nxt  = 1'b0;
        if (r_exp_in == {EW{1'b1}}) begin
          w_sign_out_nxt = r_sign_in;
          w_exp_out_nxt  = {EW{1'b1}};
          w_mant_out_nxt = '0;
          w_state_nxt    = S_DONE;
        end else if (w_carry) begin
          // A carry-out is never zero, so it skips the zero test.
          if (w_exp_inc[EW-1:0] == {EW{1'b1}}) begin
            w_sign_out_nxt = r_sign_in;
            w_exp_out_nxt  = {EW{1'b1}};
            w_mant_out_nxt = '0;
            w_ovf_nxt      = 1'b1;
            w_state_nxt    = S_DONE;
          end else begin
            w_mag_nxt   = w_abs >> 1;
            w_exp_nxt   = w_exp_inc;
            w_sign_nxt  = r_sign_in;
            w_state_nxt = S_NORM;
          end
        end else if (w_abs == '0) begin
          w_sign_out_nxt = 1'b0;
          w_exp_out_nxt  = '0;
          w_mant_out_nxt = '0;
          w_zero_nxt     = 1'b1;
          w_state_nxt    = S_DONE;
        end else begin
          w_mag_nxt   = w_abs;
          w_exp_nxt   = {1'b0, r_exp_in};
          w_sign_nxt  = w_neg ? !r_sign_in : r_sign_in;
          w_state_nxt = S_NORM;
        end
      end
      S_NORM: begin
        if (r_mag[MW-1]) begin
          w_sign_out_nxt = r_sign;
          w_exp_out_nxt  = r_exp[EW-1:0];
          w_mant_out_nxt = r_mag[MW-2:0];
          w_state_nxt    = S_DONE;
        end else if (r_exp <= {{EW{1'b0}}, 1'b1}) begin
          w_sign_out_nxt = r_sign;
          w_exp_out_nxt  = '0;
          w_mant_out_nxt = '0;
          w_unf_nxt      = 1'b1;
          w_state_nxt    = S_DONE;
        end else begin
          w_mag_nxt = r_mag << 1;
          w_exp_nxt = r_exp - {{EW{1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_zero_nxt  = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_unf_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_z        <= '0;
      r_eff_sub  <= 1'b0;
      r_sign_in  <= 1'b0;
      r_exp_in   <= '0;
      r_mag      <= '0;
      r_exp      <= '0;
      r_sign     <= 1'b0;
      r_sign_out <= 1'b0;
      r_exp_out  <= '0;
      r_mant_out <= '0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_z        <= w_z_nxt;
      r_eff_sub  <= w_eff_sub_nxt;
      r_sign_in  <= w_sign_in_nxt;
      r_exp_in   <= w_exp_in_nxt;
      r_mag      <= w_mag_nxt;
      r_exp      <= w_exp_nxt;
      r_sign     <= w_sign_nxt;
      r_sign_out <= w_sign_out_nxt;
      r_exp_out  <= w_exp_out_nxt;
      r_mant_out <= w_mant_out_nxt;
      r_zero     <= w_zero_nxt;
      r_ovf      <= w_ovf_nxt;
      r_unf      <= w_unf_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.sign_out  = r_sign_out;
  assign bus.exp_out   = r_exp_out;
  assign bus.mant_out  = r_mant_out;
  assign bus.zero_out  = r_zero;
  assign bus.ovf_out   = r_ovf;
  assign bus.unf_out   = r_unf;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_fp_sum_normalizer.sv
// Directed bench for fp_sum_normalizer: vector table for the datapath plus
// hand-written back-pressure and mid-operation reset sequences.
module tb_fp_sum_normalizer;
  localparam int MW = 24;
  localparam int EW = 8;

  typedef struct {
    logic          eff_sub;
    logic          sign_in;
    logic [EW-1:0] exp_in;
    logic [MW:0]   z_in;
    logic          e_sign;
    logic [EW-1:0] e_exp;
    logic [MW-2:0] e_mant;
    logic [2:0]    e_flags;  // {zero, ovf, unf}
    int            e_lat;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miscmp;
  vec_t vecs[12];

  fp_sum_normalizer_if #(.MW(MW), .EW(EW)) bus ();

  fp_sum_normalizer #(.MW(MW), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    if (act !== req) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] pack_out();
    return {29'd0, bus.sign_out, bus.exp_out, bus.mant_out, bus.zero_out, bus.ovf_out, bus.unf_out};
  endfunction

  function automatic logic [63:0] pack_exp(input vec_t v);
    return {29'd0, v.e_sign, v.e_exp, v.e_mant, v.e_flags};
  endfunction

  // Presents one request and returns once it has been accepted; lat is the
  // cycle count (acceptance cycle = 0) at which out_valid was first seen.
  task automatic issue(input vec_t v, output int lat);
    int guard;
    @(negedge clk);
    bus.eff_sub  = v.eff_sub;
    bus.sign_in  = v.sign_in;
    bus.exp_in   = v.exp_in;
    bus.z_in     = v.z_in;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input int idx);
    int lat;
    n_vec++;
    issue(vecs[idx], lat);
    check($sformatf("vec%0d latency", idx), 64'(lat), 64'(vecs[idx].e_lat));
    check($sformatf("vec%0d result", idx), pack_out(), pack_exp(vecs[idx]));
    @(posedge clk);
    #1;
    check($sformatf("vec%0d post-handshake {out_valid,in_ready,flags}", idx),
          {59'd0, bus.out_valid, bus.in_ready, bus.zero_out, bus.ovf_out, bus.unf_out},
          {59'd0, 1'b0, 1'b1, 3'b000});
  endtask

  initial begin
    int lat;
    int seen_valid;
    logic [63:0] held;
    n_vec = 0;
    n_miscmp = 0;
    //               sub sgn exp    z_in         sign exp    mant       flags  lat
    vecs[0]  = '{1'b0, 1'b0, 8'h80, 25'h0C00000, 1'b0, 8'h80, 23'h400000, 3'b000, 3};
    vecs[1]  = '{1'b0, 1'b0, 8'h7F, 25'h1800000, 1'b0, 8'h80, 23'h400000, 3'b000, 3};
    vecs[2]  = '{1'b1, 1'b0, 8'h85, 25'h1FFFFFF, 1'b1, 8'h6E, 23'h000000, 3'b000, 26};
    vecs[3]  = '{1'b1, 1'b1, 8'h40, 25'h0000000, 1'b0, 8'h00, 23'h000000, 3'b100, 2};
    vecs[4]  = '{1'b0, 1'b0, 8'hFE, 25'h1000000, 1'b0, 8'hFF, 23'h000000, 3'b010, 2};
    vecs[5]  = '{1'b0, 1'b1, 8'h03, 25'h0000010, 1'b1, 8'h00, 23'h000000, 3'b001, 5};
    vecs[6]  = '{1'b0, 1'b1, 8'hFF, 25'h0C00000, 1'b1, 8'hFF, 23'h000000, 3'b000, 2};
    vecs[7]  = '{1'b1, 1'b0, 8'h80, 25'h1A00000, 1'b1, 8'h7F, 23'h400000, 3'b000, 4};
    vecs[8]  = '{1'b1, 1'b1, 8'h90, 25'h0400000, 1'b1, 8'h8F, 23'h000000, 3'b000, 4};
    vecs[9]  = '{1'b0, 1'b0, 8'h10, 25'h0FFFFFF, 1'b0, 8'h10, 23'h7FFFFF, 3'b000, 3};
    vecs[10] = '{1'b0, 1'b0, 8'h01, 25'h0400000, 1'b0, 8'h00, 23'h000000, 3'b001, 3};
    vecs[11] = '{1'b0, 1'b0, 8'h02, 25'h0400000, 1'b0, 8'h01, 23'h000000, 3'b000, 4};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.z_in      = '0;
    bus.eff_sub   = 1'b0;
    bus.sign_in   = 1'b0;
    bus.exp_in    = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    check("reset outputs {in_ready,out_valid,result}", {bus.in_ready, bus.out_valid, pack_out()[61:0]}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready after reset", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 12; i++) run_vec(i);

    // back-pressure: result and in_ready must hold while out_ready is low
    n_vec++;
    bus.out_ready = 1'b0;
    issue(vecs[5], lat);
    check("hold latency", 64'(lat), 64'(vecs[5].e_lat));
    held = pack_out();
    check("hold result", held, pack_exp(vecs[5]));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold cycle %0d {out_valid,in_ready,result}", k),
            {bus.out_valid, bus.in_ready, pack_out()[61:0]}, {1'b1, 1'b0, held[61:0]});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold release {out_valid,in_ready}", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);

    // reset in the middle of the long normalization: no result may appear
    n_vec++;
    @(negedge clk);
    bus.eff_sub  = 1'b1;
    bus.sign_in  = 1'b0;
    bus.exp_in   = 8'h85;
    bus.z_in     = 25'h1FFFFFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid-norm in_ready low", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset cycle {in_ready,out_valid,result}", {bus.in_ready, bus.out_valid, pack_out()[61:0]}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready after mid-op reset", 64'(bus.in_ready), 64'd1);
    seen_valid = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.out_valid) seen_valid++;
      @(posedge clk);
      #1;
    end
    check("no out_valid for aborted op", 64'(seen_valid), 64'd0);

    // the block must still work normally after the abort
    run_vec(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
